sram16_responder: RTL and testbench

Memory-side responder for the 32-bit cache refill/writeback bus (`re`/`we`/`addr`/`dataOut`/`dataIn`/`ready`). It replaces the zero-wait behavioural memory used in simulation with a real controller for an external 16-bit asynchronous SRAM. Each 32-bit word is split into two big-endian half-word accesses with programmable wait states, and completion is signalled to the cache with a one-cycle `db_ready` pulse.

---
 rtl/sram16_responder.sv | 161 ++++++++++++++++
 tb/tb_sram16_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sram16_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram16_responder
// Description : 32-bit refill/writeback bus responder driving a 16-bit async
//               SRAM as two big-endian half-word accesses with wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module sram16_responder #(
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  db_re,
    input  logic                  db_we,
    input  logic [31:0]           db_addr,
    input  logic [31:0]           db_dataOut,
    output logic [31:0]           db_dataIn,
    output logic                  db_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]           sram_dq_out,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HI   = 2'd1;
    localparam logic [1:0] c_LO   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [4:0] c_STRB_END = 5'(WAIT_CYCLES + 1);
    localparam logic [4:0] c_LAST     = 5'(WAIT_CYCLES + 2);

    logic [1:0]            r_state, w_state_nxt;
    logic [4:0]            r_cnt, w_cnt_nxt;
    logic                  r_op, w_op_nxt;          // 1 = write
    logic [ADDR_WIDTH-2:0] r_base, w_base_nxt;      // word address (half-word pair)
    logic [31:0]           r_wdata, w_wdata_nxt;
    logic [15:0]           r_rd_hi, r_rd_lo;
    logic                  w_busy_nxt, w_strobe_nxt;

    logic [31:0]           r_data_in;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [15:0]           r_dq_out;
    logic                  r_dq_oe, r_ce_n, r_oe_n, r_we_n;

    logic                  w_unused;
    assign w_unused = ^{db_addr[31:ADDR_WIDTH+1], db_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_base_nxt  = r_base;
        w_wdata_nxt = r_wdata;
        case (r_state)
            c_IDLE: begin
                if (db_we) begin
                    w_state_nxt = c_HI;
                    w_cnt_nxt   = 5'd0;
                    w_op_nxt    = 1'b1;
                    w_base_nxt  = db_addr[ADDR_WIDTH:2];
                    w_wdata_nxt = db_dataOut;
                end else if (db_re) begin
                    w_state_nxt = c_HI;
                    w_cnt_nxt   = 5'd0;
                    w_op_nxt    = 1'b0;
                    w_base_nxt  = db_addr[ADDR_WIDTH:2];
                end
            end
            c_HI: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_LO;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            c_LO: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_DONE;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
        w_busy_nxt   = (w_state_nxt == c_HI) || (w_state_nxt == c_LO);
        w_strobe_nxt = w_busy_nxt && (w_cnt_nxt != 5'd0) && (w_cnt_nxt <= c_STRB_END);
    end

    // Pad outputs are registered from the next-state view so they line up
    // exactly with the state/cnt they describe.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= c_IDLE;
            r_cnt       <= 5'd0;
            r_op        <= 1'b0;
            r_base      <= '0;
            r_wdata     <= 32'd0;
            r_rd_hi     <= 16'd0;
            r_rd_lo     <= 16'd0;
            r_data_in   <= 32'd0;
            r_ready     <= 1'b0;
            r_sram_addr <= '0;
            r_dq_out    <= 16'd0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_base  <= w_base_nxt;
            r_wdata <= w_wdata_nxt;
            r_ready <= (w_state_nxt == c_DONE);
            r_ce_n  <= ~w_busy_nxt;
            r_oe_n  <= ~(w_strobe_nxt & ~w_op_nxt);
            r_we_n  <= ~(w_strobe_nxt & w_op_nxt);
            r_dq_oe <= w_busy_nxt & w_op_nxt;
            if (w_state_nxt == c_HI) begin
                r_sram_addr <= {w_base_nxt, 1'b0};
                r_dq_out    <= w_wdata_nxt[31:16];
            end else if (w_state_nxt == c_LO) begin
                r_sram_addr <= {w_base_nxt, 1'b1};
                r_dq_out    <= w_wdata_nxt[15:0];
            end
            // Sample read data on the edge that closes the final strobe cycle.
            if (!r_op && (r_cnt == c_STRB_END)) begin
                if (r_state == c_HI) begin
                    r_rd_hi <= sram_dq_in;
                end else if (r_state == c_LO) begin
                    r_rd_lo <= sram_dq_in;
                end
            end
            if (!r_op && (r_state == c_LO) && (w_state_nxt == c_DONE)) begin
                r_data_in <= {r_rd_hi, r_rd_lo};
            end
        end
    end

    assign db_dataIn   = r_data_in;
    assign db_ready    = r_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram16_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram16_responder
// Description : Directed bench for sram16_responder across four parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram16_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic [31:0] addr, wdata;
    logic [3:0]  re, we, ready, ce_n, oe_n, we_n, dq_oe;
    logic [31:0] din    [4];
    logic [15:0] dq_out [4];
    logic [15:0] dq_in  [4];
    logic [19:0] saddr  [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: W=1/AW=20, 1: W=0, 2: W=3, 3: W=1/AW=4
    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int WC = (i == 1) ? 0 : (i == 2) ? 3 : 1;
        localparam int AW = (i == 3) ? 4 : 20;
        logic [AW-1:0] a;
        logic [15:0]   mem [1024];

        sram16_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) u_dut (
            .clk         (clk),
            .res         (res),
            .db_re       (re[i]),
            .db_we       (we[i]),
            .db_addr     (addr),
            .db_dataOut  (wdata),
            .db_dataIn   (din[i]),
            .db_ready    (ready[i]),
            .sram_addr   (a),
            .sram_dq_out (dq_out[i]),
            .sram_dq_in  (dq_in[i]),
            .sram_dq_oe  (dq_oe[i]),
            .sram_ce_n   (ce_n[i]),
            .sram_oe_n   (oe_n[i]),
            .sram_we_n   (we_n[i])
        );

        assign saddr[i] = 20'(a);
        assign dq_in[i] = (!ce_n[i] && !oe_n[i]) ? mem[saddr[i][9:0]] : 16'hxxxx;
        always_ff @(posedge clk) begin
            if (!ce_n[i] && !we_n[i]) mem[saddr[i][9:0]] <= dq_out[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int i, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input string tag);
        int n, nwe, noe, nce, noe_pad;
        re[i] = rd; we[i] = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        n = 0; nwe = 0; noe = 0; nce = 0; noe_pad = 0;
        while (ready[i] !== 1'b1 && n < 40) begin
            if (we_n[i] === 1'b0) nwe++;
            if (oe_n[i] === 1'b0) noe++;
            if (ce_n[i] === 1'b0) nce++;
            if (dq_oe[i] === 1'b1) noe_pad++;
            @(posedge clk); #1;
            n++;
        end
        re[i] = 1'b0; we[i] = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " ce cycles"}, 32'(nce), 32'(exp_lat));
        check({tag, " we strobes"}, 32'(nwe), wr ? 32'(exp_lat - 4) : 32'd0);
        check({tag, " oe strobes"}, 32'(noe), wr ? 32'd0 : 32'(exp_lat - 4));
        check({tag, " dq_oe cycles"}, 32'(noe_pad), wr ? 32'(exp_lat) : 32'd0);
        @(posedge clk); #1;
        check({tag, " ready one cycle"}, 32'(ready[i]), 32'd0);
        @(posedge clk); #1;
        check({tag, " no extra txn"}, 32'(ce_n[i]), 32'd1);
    endtask

    initial begin
        int rcount;
        res = 1'b1; re = 4'd0; we = 4'd0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 32'(ready[0]), 32'd0);
        check("rst dataIn", din[0], 32'd0);
        check("rst addr", 32'(saddr[0]), 32'd0);
        check("rst dq_out", 32'(dq_out[0]), 32'd0);
        check("rst strobes", {28'd0, dq_oe[0], ce_n[0], oe_n[0], we_n[0]}, 32'h7);
        res = 1'b0;
        rcount = 0;
        repeat (4) begin @(posedge clk); #1; if (ready[0] !== 1'b0) rcount++; end
        check("idle no ready", 32'(rcount), 32'd0);

        // Write/read with one wait state
        txn(0, 1'b1, 1'b0, 32'h100, 32'hBADC0DE0, 8, "w1 write");
        check("w1 mem 0x80", 32'(g_dut[0].mem[10'h080]), 32'h0000BADC);
        check("w1 mem 0x81", 32'(g_dut[0].mem[10'h081]), 32'h00000DE0);
        check("w1 write keeps dataIn", din[0], 32'd0);
        txn(0, 1'b0, 1'b1, 32'h100, 32'h0, 8, "w1 read");
        check("w1 read data", din[0], 32'hBADC0DE0);

        // Zero and three wait states
        txn(1, 1'b1, 1'b0, 32'h40, 32'h12345678, 6, "w0 write");
        txn(1, 1'b0, 1'b1, 32'h40, 32'h0, 6, "w0 read");
        check("w0 read data", din[1], 32'h12345678);
        txn(2, 1'b1, 1'b0, 32'h44, 32'hA5A55A5A, 12, "w3 write");
        txn(2, 1'b0, 1'b1, 32'h44, 32'h0, 12, "w3 read");
        check("w3 read data", din[2], 32'hA5A55A5A);

        // Simultaneous requests: write wins
        txn(0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 8, "both");
        check("both mem hi", 32'(g_dut[0].mem[10'h100]), 32'h0000DEAD);
        check("both mem lo", 32'(g_dut[0].mem[10'h101]), 32'h0000BEEF);
        check("both dataIn kept", din[0], 32'hBADC0DE0);

        // Narrow address: low bits ignored, upper bits wrap
        txn(3, 1'b1, 1'b0, 32'h3, 32'h11223344, 8, "aw4 w3");
        txn(3, 1'b0, 1'b1, 32'h0, 32'h0, 8, "aw4 r0");
        check("aw4 low bits ignored", din[3], 32'h11223344);
        txn(3, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 8, "aw4 w20");
        check("aw4 wrap mem0", 32'(g_dut[3].mem[10'h000]), 32'h0000CAFE);
        txn(3, 1'b0, 1'b1, 32'h0, 32'h0, 8, "aw4 r0b");
        check("aw4 wrap read", din[3], 32'hCAFEF00D);

        // Reset during the low half-word strobe of a write
        we[0] = 1'b1; addr = 32'h300; wdata = 32'h55AA1234;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        check("mid LO strobe we_n", 32'(we_n[0]), 32'd0);
        check("mid LO addr", 32'(saddr[0]), 32'h181);
        res = 1'b1; we[0] = 1'b0;
        @(posedge clk); #1;
        check("abort we_n", 32'(we_n[0]), 32'd1);
        check("abort ce_n", 32'(ce_n[0]), 32'd1);
        check("abort ready", 32'(ready[0]), 32'd0);
        res = 1'b0;
        rcount = 0;
        repeat (12) begin @(posedge clk); #1; if (ready[0] !== 1'b0) rcount++; end
        check("abort no ready", 32'(rcount), 32'd0);
        check("abort hi written", 32'(g_dut[0].mem[10'h180]), 32'h000055AA);
        txn(0, 1'b0, 1'b1, 32'h100, 32'h0, 8, "post abort read");
        check("post abort data", din[0], 32'hBADC0DE0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
